// File: rtl/ipb_io_bridge.sv
// IPbus strobe to slow IO target bridge: sustained read enable or timed write pulse, one-cycle ack/err, post-transaction hold.
// Latency: read ack RD_DLY+1 cycles after io_rd_ack is sampled; write ack WR_PULSE+2 cycles after the strobe.
// Backpressure: strobes are sampled only in IDLE; define IPB_IO_TIMEOUT_EN for the read timeout and err_count.
module ipb_io_bridge #(
    parameter int unsigned RD_DLY   = 2,
    parameter int unsigned HOLD     = 3,
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ipb_strobe,
    input  logic       ipb_write,
    input  logic       io_rd_ack,
    output logic       io_rd_en,
    output logic       io_wr_en,
    output logic       io_sync,
    output logic       ipb_ack,
    output logic       ipb_err,
    output logic [7:0] err_count
);

    localparam logic [15:0] RD_LAST   = (RD_DLY > 0)   ? 16'(RD_DLY - 1)   : 16'd0;
    localparam logic [15:0] HOLD_LAST = (HOLD > 0)     ? 16'(HOLD - 1)     : 16'd0;
    localparam logic [15:0] WR_LAST   = (WR_PULSE > 0) ? 16'(WR_PULSE - 1) : 16'd0;
    localparam logic [15:0] TMO_LAST  = (TIMEOUT > 0)  ? 16'(TIMEOUT - 1)  : 16'd0;

`ifdef IPB_IO_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_START,
        S_RD_WAIT,
        S_RD_DLY,
        S_RD_ACK,
        S_RD_ERR,
        S_WR_START,
        S_WR_EN,
        S_WR_ACK,
        S_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        hold_rd, hold_rd_nxt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hold_rd <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hold_rd <= hold_rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ipb_strobe) state_nxt = ipb_write ? S_WR_START : S_RD_START;
            end
            S_RD_START: state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                // A late ack in the expiry cycle still wins over the timeout.
                if (io_rd_ack)                        state_nxt = (RD_DLY == 0) ? S_RD_ACK : S_RD_DLY;
                else if (TMO_EN && cnt == TMO_LAST)   state_nxt = S_RD_ERR;
            end
            S_RD_DLY: begin
                if (cnt == RD_LAST) state_nxt = S_RD_ACK;
            end
            S_RD_ACK, S_RD_ERR, S_WR_ACK: state_nxt = (HOLD == 0) ? S_IDLE : S_HOLD;
            S_WR_START: state_nxt = S_WR_EN;
            S_WR_EN: begin
                if (cnt == WR_LAST) state_nxt = S_WR_ACK;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // One shared counter measures time spent in the current state.
        cnt_nxt     = (state_nxt != state || state == S_IDLE) ? 16'd0 : cnt + 16'd1;
        hold_rd_nxt = (state == S_HOLD) ? hold_rd : (state == S_RD_ACK);
    end

    assign io_rd_en = (state == S_RD_START) || (state == S_RD_WAIT) || (state == S_RD_DLY) ||
                      (state == S_RD_ACK) || (state == S_HOLD && hold_rd);
    assign io_wr_en = (state == S_WR_EN);
    assign io_sync  = (state != S_IDLE);
    assign ipb_ack  = (state == S_RD_ACK) || (state == S_WR_ACK);

`ifdef IPB_IO_TIMEOUT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)                                    err_cnt <= '0;
        else if (state == S_RD_ERR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign err_count = err_cnt;
    assign ipb_err   = (state == S_RD_ERR);
`else
    assign err_count = '0;
    assign ipb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ipb_io_bridge.sv
// Randomized scoreboard bench for ipb_io_bridge: two instances with different timing parameters.
module tb_ipb_io_bridge;

    localparam int RD_A = 2, HOLD_A = 3, WP_A = 1, TMO_A = 4;
    localparam int RD_B = 0, HOLD_B = 0, WP_B = 3, TMO_B = 3;
`ifdef IPB_IO_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int MAXC = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] res_n, strobe, write, rdack;
    wire  [1:0] rd_en, wr_en, sync, ack, err;
    wire  [7:0] ec0, ec1;

    ipb_io_bridge #(.RD_DLY(RD_A), .HOLD(HOLD_A), .WR_PULSE(WP_A), .TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .res_n(res_n[0]), .ipb_strobe(strobe[0]), .ipb_write(write[0]),
        .io_rd_ack(rdack[0]), .io_rd_en(rd_en[0]), .io_wr_en(wr_en[0]), .io_sync(sync[0]),
        .ipb_ack(ack[0]), .ipb_err(err[0]), .err_count(ec0)
    );

    ipb_io_bridge #(.RD_DLY(RD_B), .HOLD(HOLD_B), .WR_PULSE(WP_B), .TIMEOUT(TMO_B)) dut_b (
        .clk(clk), .res_n(res_n[1]), .ipb_strobe(strobe[1]), .ipb_write(write[1]),
        .io_rd_ack(rdack[1]), .io_rd_en(rd_en[1]), .io_wr_en(wr_en[1]), .io_sync(sync[1]),
        .ipb_ack(ack[1]), .ipb_err(err[1]), .err_count(ec1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {rd_en, wr_en, sync} per cycle, expected err_count (-1 = unchecked) per cycle.
    bit [2:0] exp_o  [2][MAXC];
    int       exp_ec [2][MAXC];
    int       ec_m   [2];
    bit [1:0] chk_en;
    int       q0 [$];
    int       q1 [$];

    function automatic int prm_rd(int d);   return d == 0 ? RD_A   : RD_B;   endfunction
    function automatic int prm_hold(int d); return d == 0 ? HOLD_A : HOLD_B; endfunction
    function automatic int prm_wp(int d);   return d == 0 ? WP_A   : WP_B;   endfunction
    function automatic int prm_tmo(int d);  return d == 0 ? TMO_A  : TMO_B;  endfunction
    function automatic int ecnt(int d);     return d == 0 ? int'(ec0) : int'(ec1); endfunction

    task automatic chk(string name, int d, int act, int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", name, d, cyc, act, expv);
        end
    endtask

    task automatic push(int d, int code);
        if (d == 0) q0.push_back(code);
        else        q1.push_back(code);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle compares enables and err_count; each ack/err pops the scoreboard.
    always @(negedge clk) begin
        int got, want;
        for (int d = 0; d < 2; d++) begin
            if (chk_en[d] && cyc < MAXC) begin
                chk("outs_rd_wr_sync", d, int'({rd_en[d], wr_en[d], sync[d]}), int'(exp_o[d][cyc]));
                if (exp_ec[d][cyc] >= 0) chk("err_count", d, ecnt(d), exp_ec[d][cyc]);
                if (ack[d] || err[d]) begin
                    chk("ack_err_exclusive", d, int'(ack[d] & err[d]), 0);
                    got = cyc * 2 + int'(err[d]);
                    if (d == 0) want = (q0.size() > 0) ? q0.pop_front() : -1;
                    else        want = (q1.size() > 0) ? q1.pop_front() : -1;
                    chk("resp_cycle_kind", d, got, want);
                end
            end
        end
    end

    task automatic idle_cycles(int d, int n);
        for (int i = 0; i < n; i++) begin
            step();
            strobe[d] = 1'b0;
            write[d]  = 1'($urandom);
            rdack[d]  = 1'($urandom);
            exp_ec[d][cyc] = ec_m[d];
        end
    endtask

    // k = cycle in which io_rd_ack first goes high (0 = never). Returns in the first IDLE cycle.
    task automatic txn(int d, bit wr, int k);
        int base, rsp, idle, rd_last, t;
        bit e;
        t    = prm_tmo(d);
        base = cyc;
        e    = 1'b0;
        if (base + 64 >= MAXC) begin
            $display("FAIL cycle_budget dut%0d: cycle %0d exceeds limit %0d", d, base, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (wr) begin
            rsp     = 2 + prm_wp(d);
            rd_last = 0;
            for (int n = 2; n <= 1 + prm_wp(d); n++) exp_o[d][base + n][1] = 1'b1;
        end else begin
            e       = TMO_EN && (k == 0 || k > t + 1);
            rsp     = e ? t + 2 : k + 1 + prm_rd(d);
            rd_last = e ? t + 1 : rsp + prm_hold(d);
        end
        idle = rsp + 1 + prm_hold(d);
        for (int n = 1; n < idle; n++) begin
            exp_o[d][base + n][0] = 1'b1;
            if (n <= rd_last) exp_o[d][base + n][2] = 1'b1;
        end
        exp_ec[d][base] = ec_m[d];
        if (e && ec_m[d] < 255) ec_m[d]++;
        push(d, (base + rsp) * 2 + int'(e));

        strobe[d] = 1'b1;
        write[d]  = wr;
        rdack[d]  = 1'($urandom);
        for (int n = 1; n <= idle; n++) begin
            step();
            strobe[d] = (n < idle) ? 1'($urandom) : 1'b0;
            write[d]  = 1'($urandom);
            if (wr || n < 2) rdack[d] = 1'($urandom);
            else if (e)      rdack[d] = (n <= t + 1) ? 1'b0 : 1'($urandom);
            else             rdack[d] = (n < k) ? 1'b0 : (n == k) ? 1'b1 : 1'($urandom);
        end
        exp_ec[d][cyc] = ec_m[d];
    endtask

    // Start a transaction, pull reset in its third cycle, check the async drop, then release.
    task automatic abort_txn(int d, bit wr);
        chk_en[d] = 1'b0;
        strobe[d] = 1'b1;
        write[d]  = wr;
        rdack[d]  = 1'b0;
        step();
        strobe[d] = 1'b0;
        step();
        #2;
        chk("pre_reset_busy", d, int'({rd_en[d], wr_en[d], sync[d]}), wr ? 3 : 5);
        res_n[d] = 1'b0;
        #1;
        chk("reset_async_outs", d, int'({rd_en[d], wr_en[d], sync[d], ack[d], err[d]}), 0);
        chk("reset_async_errcnt", d, ecnt(d), 0);
        step();
        step();
        res_n[d]       = 1'b1;
        ec_m[d]        = 0;
        exp_ec[d][cyc] = 0;
        chk_en[d]      = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, k;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < MAXC; c++) begin
                exp_o[i][c]  = 3'b000;
                exp_ec[i][c] = -1;
            end
            ec_m[i] = 0;
        end
        chk_en = 2'b00;
        res_n  = 2'b00;
        strobe = 2'b00;
        write  = 2'b00;
        rdack  = 2'b00;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("reset_outs", i, int'({rd_en[i], wr_en[i], sync[i], ack[i], err[i]}), 0);
            chk("reset_errcnt", i, ecnt(i), 0);
        end
        res_n = 2'b11;
        exp_ec[0][cyc] = 0;
        exp_ec[1][cyc] = 0;
        chk_en = 2'b11;
        idle_cycles(0, 2);

        txn(0, 1'b0, 4);
        idle_cycles(0, 2);
        txn(0, 1'b1, 0);
        txn(1, 1'b1, 0);
        txn(1, 1'b1, 0);
        txn(1, 1'b0, 2);
`ifdef IPB_IO_TIMEOUT_EN
        txn(0, 1'b0, 0);
        txn(0, 1'b0, 5);
        txn(1, 1'b0, 0);
        txn(1, 1'b0, 4);
`endif

        for (int i = 0; i < 250; i++) begin
            d = int'($urandom_range(0, 1));
`ifdef IPB_IO_TIMEOUT_EN
            k = int'($urandom_range(0, prm_tmo(d) + 3));
            if (k == 1) k = 0;
`else
            k = int'($urandom_range(2, 8));
`endif
            txn(d, 1'($urandom), k);
            if ($urandom_range(0, 2) == 0) idle_cycles(d, int'($urandom_range(1, 3)));
        end

`ifdef IPB_IO_TIMEOUT_EN
        for (int i = 0; i < 300; i++) txn(0, 1'b0, 0);
        chk("err_count_saturated", 0, ecnt(0), 255);
`endif

        abort_txn(0, 1'b0);
        txn(0, 1'b1, 0);
        abort_txn(1, 1'b1);
        txn(1, 1'b1, 0);
        idle_cycles(0, 3);

        chk("scoreboard_drained", 0, q0.size(), 0);
        chk("scoreboard_drained", 1, q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipb_io_bridge.md
# ipb_io_bridge

Parametrised IPbus-to-IO handshake bridge; next generation of the fixed-timing IPbus IO interface FSM. Sits between an IPbus slave port and a slow register/IO target. Turns a single-cycle IPbus strobe into a sustained read-enable or a timed write pulse, returns a one-cycle ack, and enforces post-transaction hold time. Adds programmable delays, a configurable write-pulse width and an optional read timeout with error reporting, none of which the previous block had.

## Interface
Parameters:
- RD_DLY, 2: cycles between sampled io_rd_ack and ipb_ack; legal 0..15
- HOLD, 3: hold cycles after ack/err before returning to IDLE; legal 0..15
- WR_PULSE, 1: io_wr_en width in cycles; legal 1..15
- TIMEOUT, 255: max cycles spent in RD_WAIT; legal 1..65535 (used only with IPB_IO_TIMEOUT_EN)

Ports:
- clk  in  1  IPbus clock; all logic on rising edge
- res_n  in  1  asynchronous, active-low reset
- ipb_strobe  in  1  IPbus strobe; sampled only in IDLE
- ipb_write  in  1  1 = write, 0 = read; sampled with strobe
- io_rd_ack  in  1  target read-data-valid; sampled only in RD_WAIT
- io_rd_en  out  1  read enable, held from RD_START through read HOLD
- io_wr_en  out  1  write enable, high exactly WR_PULSE cycles
- io_sync  out  1  high in every state except IDLE
- ipb_ack  out  1  one-cycle ack to IPbus
- ipb_err  out  1  one-cycle error to IPbus (read timeout)
- err_count  out  8  saturating count of read timeouts

## Operation
- States: IDLE, RD_START, RD_WAIT, RD_DLY, RD_ACK, RD_ERR, WR_START, WR_EN, WR_ACK, HOLD.
- All outputs are Moore decodes of the registered state/counters. No combinational input-to-output path.
- Reset (async assert, sync release): state IDLE, all counters 0, all outputs 0. err_count is cleared only by reset.
- IDLE: strobe & !write -> RD_START; strobe & write -> WR_START; otherwise stay.
- RD_START (1 cycle) -> RD_WAIT.
- RD_WAIT: io_rd_ack -> RD_DLY, or RD_ACK if RD_DLY=0.
- RD_DLY: stays RD_DLY cycles -> RD_ACK.
- RD_ACK (1 cycle, ipb_ack=1) -> HOLD, or IDLE if HOLD=0.
- WR_START (1 cycle, no enables) -> WR_EN (WR_PULSE cycles, io_wr_en=1) -> WR_ACK (1 cycle, ipb_ack=1) -> HOLD/IDLE.
- HOLD: HOLD cycles -> IDLE.
  - io_rd_en stays 1 in HOLD when HOLD was entered from RD_ACK.
  - io_rd_en is 0 in HOLD after a write or an RD_ERR.
- Timeout (macro on): a cycle counter starts at 0 on RD_WAIT entry.
  - If io_rd_ack is low in the TIMEOUT-th RD_WAIT cycle -> RD_ERR.
  - RD_ERR: 1 cycle, ipb_err=1, io_rd_en=0, err_count += 1 saturating at 255 -> HOLD/IDLE.
- ipb_ack and ipb_err are never high together. Each transaction produces exactly one of them.
- ipb_strobe, ipb_write and io_rd_ack changes outside their sampling states are ignored.

## Timing
- Cycle 0 = IDLE edge sampling the strobe.
- Read, ack sampled in cycle k≥2: ipb_ack in cycle k+1+RD_DLY; IDLE in cycle k+2+RD_DLY+HOLD. Defaults with k=2: ack in cycle 5, io_rd_en high cycles 1..8, IDLE at 9.
- Write: io_wr_en high in cycles 2..1+WR_PULSE; ipb_ack in cycle 2+WR_PULSE; IDLE at 3+WR_PULSE+HOLD. Defaults: wr_en cycle 2, ack 3, IDLE 7.
- Timeout: RD_WAIT occupies cycles 2..TIMEOUT+1; ipb_err in cycle TIMEOUT+2.
- io_rd_ack high in the expiry cycle itself: the ack wins, with no error and no count increment.
- Minimum back-to-back spacing: next strobe is sampled in the first IDLE cycle.
- Reset mid-transaction: all outputs drop asynchronously and no ack or err is issued for the aborted transaction.

## Configuration
- IPB_IO_TIMEOUT_EN defined: timeout counter, RD_ERR state and err_count logic are built as described.
- IPB_IO_TIMEOUT_EN undefined: RD_WAIT waits indefinitely, RD_ERR is unreachable or removed, ipb_err is tied 0 and err_count is tied 0. The TIMEOUT parameter is ignored.

## Test plan
- Defaults, read with io_rd_ack pulsed in cycle 4 -> ipb_ack only in cycle 7, io_rd_en high cycles 1..10, io_sync high 1..10, IDLE at 11.
- WR_PULSE=3, HOLD=0, write strobe -> io_wr_en high cycles 2..4, ipb_ack cycle 5, IDLE cycle 6, io_rd_en never high.
- Macro on, TIMEOUT=4, read with no io_rd_ack -> ipb_err in cycle 6 only, no ipb_ack, err_count 0->1; 300 such reads -> err_count saturates at 255.
- Macro on, TIMEOUT=4, io_rd_ack first high in cycle 5 (expiry cycle) -> ipb_ack in cycle 8, ipb_err never, err_count unchanged.
- Strobe toggled during HOLD plus back-to-back strobes -> extra strobes ignored; next transaction starts only from IDLE; exactly one ack per accepted strobe.
- res_n asserted during RD_WAIT and during WR_EN -> all outputs 0 immediately; after release the FSM is in IDLE and a fresh write completes normally.
